// File: rtl/ram_pkg.sv
// Shared types for the chip-selected single-port RAM family.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } ram_state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/ram_sp_cs_param.sv
// Parametrised single-port synchronous RAM with chip select, self-clear sequence
// and registered read-valid / ack handshake.
module ram_sp_cs_param
  import ram_pkg::*;
#(
  parameter int                ADDR_W   = 4,
  parameter int                DATA_W   = 8,
  parameter int                CS_W     = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CS_W-1:0]   cs,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_oe,
  output logic              busy,
  output logic              ack
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              sel, accept, rd_accept, we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wd;

  assign sel       = &cs;
  assign rd_accept = accept & (rw == RW_READ);
  assign busy      = (state_q == ST_CLEAR);

  // Clear sequence and user writes share the single write port.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    accept    = 1'b0;
    we        = 1'b0;
    waddr     = addr;
    wd        = wdata;
    unique case (state_q)
      ST_CLEAR: begin
        if (clr) begin
          clr_ptr_d = '0;
        end else begin
          we        = 1'b1;
          waddr     = clr_ptr_q;
          wd        = INIT_VAL;
          clr_ptr_d = clr_ptr_q + 1'b1;
          if (&clr_ptr_q) state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end else begin
          accept = req & sel;
          we     = accept & (rw == RW_WRITE);
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      rdata     <= '0;
      rdata_oe  <= 1'b0;
      ack       <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ack       <= accept;
      rdata_oe  <= rd_accept;
      if (rd_accept) rdata <= mem[addr];
    end
  end

  // Reset wins over any write that would otherwise land this cycle.
  always_ff @(posedge clk) begin
    if (we && rst_n) mem[waddr] <= wd;
  end

endmodule

// File: tb/tb_ram_sp_cs_param.sv
// Bench for ram_sp_cs_param: directed table, multi-cycle corner sequences,
// randomized traffic against a reference model, and a wide-parameter instance.
module tb_ram_sp_cs_param;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, req = 1'b0, rw = 1'b0, clr = 1'b0;
  logic [3:0] cs = 4'hF, addr = '0;
  logic [7:0] wdata = '0, rdata;
  logic       rdata_oe, busy, ack;

  logic        rst2_n = 1'b0, req2 = 1'b0, rw2 = 1'b0, clr2 = 1'b0;
  logic [1:0]  cs2 = 2'b11;
  logic [5:0]  addr2 = '0;
  logic [15:0] wdata2 = '0, rdata2;
  logic        rdata_oe2, busy2, ack2;

  always #5 clk = ~clk;

  ram_sp_cs_param dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .req(req), .rw(rw), .addr(addr),
    .wdata(wdata), .clr(clr), .rdata(rdata), .rdata_oe(rdata_oe), .busy(busy), .ack(ack)
  );

  ram_sp_cs_param #(.ADDR_W(6), .DATA_W(16), .CS_W(2), .INIT_VAL(16'hBEEF)) dut2 (
    .clk(clk), .rst_n(rst2_n), .cs(cs2), .req(req2), .rw(rw2), .addr(addr2),
    .wdata(wdata2), .clr(clr2), .rdata(rdata2), .rdata_oe(rdata_oe2), .busy(busy2), .ack(ack2)
  );

  int nvec = 0, nerr = 0;

  // Reference model: words left to clear, memory image, registered outputs.
  int         m_left = DEPTH;
  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_rdata = '0;
  logic       m_oe = 1'b0, m_ack = 1'b0;

  task automatic tick();
    if (!rst_n) begin
      m_left = DEPTH; m_rdata = '0; m_oe = 1'b0; m_ack = 1'b0;
    end else if (m_left != 0) begin
      m_oe = 1'b0; m_ack = 1'b0;
      if (clr) m_left = DEPTH;
      else begin
        m_left--;
        if (m_left == 0) foreach (m_mem[i]) m_mem[i] = 8'h00;
      end
    end else if (clr) begin
      m_left = DEPTH; m_oe = 1'b0; m_ack = 1'b0;
    end else if (req && cs == 4'hF) begin
      m_ack = 1'b1;
      if (rw) begin m_mem[addr] = wdata; m_oe = 1'b0; end
      else begin m_rdata = m_mem[addr]; m_oe = 1'b1; end
    end else begin
      m_ack = 1'b0; m_oe = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    nvec++;
    if (busy !== (m_left != 0) || ack !== m_ack || rdata_oe !== m_oe || rdata !== m_rdata) begin
      nerr++;
      $display("FAIL model t=%0t: busy/ack/oe/rdata got %b/%b/%b/%h want %b/%b/%b/%h",
               $time, busy, ack, rdata_oe, rdata, (m_left != 0), m_ack, m_oe, m_rdata);
    end
  endtask

  task automatic idle();
    req = 1'b0; rw = 1'b0; clr = 1'b0; cs = 4'hF;
  endtask

  // Counts cycles from the current busy sample until busy falls (bounded).
  task automatic count_clear(input string nm, input int want);
    int n = 0;
    idle();
    while (busy === 1'b1 && n < 200) begin tick(); n++; end
    nvec++;
    if (n != want) begin
      nerr++;
      $display("FAIL %s: busy cycles got %0d want %0d", nm, n, want);
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] want, input string nm);
    cs = 4'hF; req = 1'b1; rw = 1'b0; addr = a;
    tick();
    idle();
    nvec++;
    if (rdata !== want || rdata_oe !== 1'b1 || ack !== 1'b1) begin
      nerr++;
      $display("FAIL %s: rdata/oe/ack got %h/%b/%b want %h/1/1", nm, rdata, rdata_oe, ack, want);
    end
  endtask

  typedef struct {
    logic [3:0] cs; logic req, rw; logic [3:0] addr; logic [7:0] wdata; logic clr;
    logic e_ack, e_oe; logic [7:0] e_rdata; logic e_busy;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{4'hF, 1, 1, 4'd3,  8'hA5, 0, 1, 0, 8'h00, 0};
    tbl[1]  = '{4'hF, 1, 1, 4'd15, 8'h5A, 0, 1, 0, 8'h00, 0};
    tbl[2]  = '{4'hF, 1, 0, 4'd3,  8'h00, 0, 1, 1, 8'hA5, 0};
    tbl[3]  = '{4'hF, 0, 0, 4'd0,  8'h00, 0, 0, 0, 8'hA5, 0};
    tbl[4]  = '{4'hF, 1, 0, 4'd15, 8'h00, 0, 1, 1, 8'h5A, 0};
    tbl[5]  = '{4'hE, 1, 1, 4'd3,  8'hFF, 0, 0, 0, 8'h5A, 0};
    tbl[6]  = '{4'hE, 1, 0, 4'd3,  8'h00, 0, 0, 0, 8'h5A, 0};
    tbl[7]  = '{4'hF, 1, 0, 4'd3,  8'h00, 0, 1, 1, 8'hA5, 0};
    tbl[8]  = '{4'hF, 1, 1, 4'd7,  8'h11, 0, 1, 0, 8'hA5, 0};
    tbl[9]  = '{4'hF, 1, 0, 4'd7,  8'h00, 0, 1, 1, 8'h11, 0};
    tbl[10] = '{4'hF, 1, 1, 4'd1,  8'h22, 1, 0, 0, 8'h11, 1};

    // Reset for 3 cycles, then a full 16-cycle clear.
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    count_clear("reset_clear", DEPTH);
    for (int a = 0; a < DEPTH; a++) rd(4'(a), 8'h00, "post_reset_read");

    // Directed table: write/read, chip select, back-to-back, clr with req.
    for (int i = 0; i < 11; i++) begin
      cs = tbl[i].cs; req = tbl[i].req; rw = tbl[i].rw; addr = tbl[i].addr;
      wdata = tbl[i].wdata; clr = tbl[i].clr;
      tick();
      nvec++;
      if (ack !== tbl[i].e_ack || rdata_oe !== tbl[i].e_oe || rdata !== tbl[i].e_rdata || busy !== tbl[i].e_busy) begin
        nerr++;
        $display("FAIL tbl[%0d]: ack/oe/rdata/busy got %b/%b/%h/%b want %b/%b/%h/%b", i,
                 ack, rdata_oe, rdata, busy, tbl[i].e_ack, tbl[i].e_oe, tbl[i].e_rdata, tbl[i].e_busy);
      end
    end
    count_clear("clr_clear", DEPTH);
    rd(4'd1, 8'h00, "clr_read1");
    rd(4'd3, 8'h00, "clr_read3");

    // Reset at clear cycle 5 restarts the whole sequence.
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0; repeat (2) tick(); rst_n = 1'b1;
    count_clear("reset_mid_clear", DEPTH);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(149) != 0);
      clr   = ($urandom_range(59) == 0);
      cs    = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
      req   = ($urandom_range(3) != 0);
      rw    = 1'($urandom);
      addr  = 4'($urandom);
      wdata = 8'($urandom);
      tick();
    end
    rst_n = 1'b1; idle();
    tick();

    // Wide instance: 64-cycle clear, every word reads back INIT_VAL.
    @(negedge clk);
    rst2_n = 1'b1;
    begin
      int n = 0;
      while (busy2 === 1'b1 && n < 300) begin @(posedge clk); @(negedge clk); n++; end
      nvec++;
      if (n != 64) begin nerr++; $display("FAIL sweep_clear: busy cycles got %0d want 64", n); end
    end
    for (int a = 0; a < 64; a++) begin
      req2 = 1'b1; rw2 = 1'b0; addr2 = 6'(a);
      @(posedge clk); @(negedge clk);
      nvec++;
      if (rdata2 !== 16'hBEEF || rdata_oe2 !== 1'b1 || ack2 !== 1'b1) begin
        nerr++;
        $display("FAIL sweep_read@%0d: rdata/oe/ack got %h/%b/%b want beef/1/1", a, rdata2, rdata_oe2, ack2);
      end
    end
    req2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
